// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store bus bridge.
//   lsu_state_e : bridge FSM encoding (IDLE, REQ, WAIT, DONE)
//   LS_*        : funct3 access size/sign codes
//   TO_CNT_W    : width of the bus timeout counter
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  localparam int TO_CNT_W = 16;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the load/store bridge (purely combinational).
// Ports:
//   funct3_i  : access size/sign (funct3[1]=1 means word)
//   addr_lo_i : low two byte-address bits
//   wdata_i   : right-aligned store data
//   rword_i   : bus read word
//   be_o      : byte enables
//   wdata_o   : lane-replicated store data
//   rdata_o   : selected and sign/zero-extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rword_i[{addr_lo_i, 3'b000} +: 8];
    // half accesses ignore addr[0]
    half_sel = rword_i[{addr_lo_i[1], 4'b0000} +: 16];
    be_o     = 4'b1111;
    wdata_o  = wdata_i;
    rdata_o  = rword_i;
    case (funct3_i[1:0])
      LS_B[1:0]: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = (funct3_i == LS_BU) ? {24'h000000, byte_sel}
                                      : {{24{byte_sel[7]}}, byte_sel};
      end
      LS_H[1:0]: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = (funct3_i == LS_HU) ? {16'h0000, half_sel}
                                      : {{16{half_sel[15]}}, half_sel};
      end
      default: ;  // 010/011/11x are word accesses
    endcase
  end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Load/store bridge between EX/MEM and a req/gnt/rvalid data bus.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word accesses
// skip the bus, pulse err and return rdata=0).
// Ports:
//   clk, rst (async, active-low), enable (global freeze when low)
//   mem_rd, mem_wr, funct3, addr, wdata : access from EX/MEM (rd has priority)
//   rdata  : registered, extended load result (valid in DONE)
//   stall  : pipeline freeze while an access is pending
//   err    : one-cycle pulse on timeout / misalignment trap
//   bus_req, bus_we, bus_addr, bus_be, bus_wdata : registered bus request
//   bus_gnt, bus_rvalid, bus_rdata              : bus responses
module lsu_bus_bridge
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam logic [TO_CNT_W-1:0] TMO_LAST = TO_CNT_W'(TIMEOUT - 1);

  lsu_state_e          state_q, state_d;
  logic [TO_CNT_W-1:0] cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [1:0]          alo_q, alo_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [31:0]         bus_addr_q, bus_addr_d;
  logic [3:0]          bus_be_q, bus_be_d;
  logic [31:0]         bus_wdata_q, bus_wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [2:0]          al_f3;
  logic [1:0]          al_alo;
  logic [3:0]          al_be;
  logic [31:0]         al_wdata;
  logic [31:0]         al_rdata;
  logic                access;
  logic                misalign;
  logic                fin;

  // One aligner serves both directions: live inputs while issuing from IDLE,
  // the latched access while waiting for read data.
  assign al_f3  = (state_q == ST_IDLE) ? funct3 : f3_q;
  assign al_alo = (state_q == ST_IDLE) ? addr[1:0] : alo_q;

  lsu_align u_align (
    .funct3_i  (al_f3),
    .addr_lo_i (al_alo),
    .wdata_i   (wdata),
    .rword_i   (bus_rdata),
    .be_o      (al_be),
    .wdata_o   (al_wdata),
    .rdata_o   (al_rdata)
  );

  assign access = mem_rd | mem_wr;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (funct3[1] & (addr[1:0] != 2'b00)) |
                    ((funct3[1:0] == 2'b01) & addr[0]);
`else
  assign misalign = 1'b0;
`endif

  // Read completes on gnt+rvalid in REQ or rvalid in WAIT; writes on gnt.
  assign fin = ((state_q == ST_REQ) & bus_gnt & (we_q | bus_rvalid)) |
               ((state_q == ST_WAIT) & bus_rvalid);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    f3_d        = f3_q;
    alo_d       = alo_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    if (enable) begin
      err_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (access) begin
            we_d  = ~mem_rd;
            f3_d  = funct3;
            alo_d = addr[1:0];
            if (misalign) begin
              state_d = ST_DONE;
              err_d   = 1'b1;
              rdata_d = 32'h0;
            end else begin
              state_d     = ST_REQ;
              cnt_d       = '0;
              bus_req_d   = 1'b1;
              bus_we_d    = ~mem_rd;
              bus_addr_d  = {addr[31:2], 2'b00};
              bus_be_d    = al_be;
              bus_wdata_d = al_wdata;
            end
          end
        end
        ST_REQ, ST_WAIT: begin
          if (fin) begin
            state_d   = ST_DONE;
            bus_req_d = 1'b0;
            if (!we_q) rdata_d = al_rdata;
          end else if (cnt_q == TMO_LAST) begin
            state_d   = ST_DONE;
            bus_req_d = 1'b0;
            err_d     = 1'b1;
            rdata_d   = 32'h0;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if ((state_q == ST_REQ) && bus_gnt) begin
              state_d   = ST_WAIT;
              bus_req_d = 1'b0;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      alo_q       <= 2'b00;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      alo_q       <= alo_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // stall is combinational, so it is gated by rst to read 0 during reset.
  assign stall = rst & (((state_q == ST_IDLE) & enable & access) |
                        (state_q == ST_REQ) | (state_q == ST_WAIT));

  assign rdata     = rdata_q;
  assign err       = err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
`timescale 1ns/1ps
module tb_lsu_bus_bridge;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        stall, err, bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  int errors = 0;
  int checks = 0;

  // expected outputs for the current cycle, set by the stimulus side
  bit          chk_on = 1'b0;
  bit          chk_bus = 1'b0;
  logic        exp_stall = 1'b0, exp_req = 1'b0, exp_err = 1'b0, exp_we = 1'b0;
  logic [31:0] exp_rdata = 32'h0, exp_addr = 32'h0, exp_wd = 32'h0;
  logic [3:0]  exp_be = 4'h0;
  logic [31:0] rd_hold = 32'h0;

  // observation counters and last granted request
  int          stall_cnt = 0, req_cnt = 0, err_cnt = 0;
  logic [31:0] last_addr = 32'h0, last_wd = 32'h0;
  logic [3:0]  last_be = 4'h0;

  lsu_bus_bridge #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
    .err(err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- reference model: access rules as plain arithmetic ----
  function automatic logic [3:0] m_be(input logic [2:0] f, input logic [31:0] a);
    if (f[1]) return 4'hF;
    if (f[0]) return a[1] ? 4'b1100 : 4'b0011;
    return 4'(1 << a[1:0]);
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f, input logic [31:0] w);
    if (f[1]) return w;
    if (f[0]) return {w[15:0], w[15:0]};
    return {w[7:0], w[7:0], w[7:0], w[7:0]};
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] w);
    longint v;
    int     sh, bits;
    if (f[1]) return w;
    bits = f[0] ? 16 : 8;
    sh   = f[0] ? (a[1] ? 16 : 0) : 8 * int'(a[1:0]);
    v    = (longint'(w) >> sh) & ((longint'(1) << bits) - 1);
    if (!f[2] && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return v[31:0];
  endfunction

  function automatic bit m_mis(input logic [2:0] f, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    if (f[1]) return a[1:0] != 2'b00;
    if (f[0]) return a[0];
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // ---- single compare process ----
  always @(negedge clk) begin
    if (chk_on) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("bus_req", 32'(bus_req), 32'(exp_req));
      chk("err", 32'(err), 32'(exp_err));
      chk("rdata", rdata, exp_rdata);
      if (chk_bus) begin
        chk("bus_we", 32'(bus_we), 32'(exp_we));
        chk("bus_addr", bus_addr, exp_addr);
        chk("bus_be", 32'(bus_be), 32'(exp_be));
        if (exp_we) chk("bus_wdata", bus_wdata, exp_wd);
      end
    end
  end

  always @(negedge clk) begin
    if (stall) stall_cnt++;
    if (bus_req) req_cnt++;
    if (err) err_cnt++;
    if (bus_req && bus_gnt) begin
      last_addr = bus_addr;
      last_be   = bus_be;
      last_wd   = bus_wdata;
    end
  end

  task automatic set_idle();
    exp_stall = 1'b0; exp_req = 1'b0; exp_err = 1'b0; chk_bus = 1'b0;
    exp_rdata = rd_hold;
  endtask

  // One access, called just after a rising edge with the DUT idle and enable high.
  // g: REQ cycles before gnt; r: cycles from gnt to rvalid (reads).
  task automatic txn(input bit rd, input bit wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int g, input int r, input logic [31:0] rw);
    bit mis, fin, tmo;
    int n;
    mis = m_mis(f3, a);
    mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = wd;
    bus_gnt = 1'b0; bus_rvalid = 1'($urandom % 2); bus_rdata = $urandom;
    exp_we = !rd; exp_addr = {a[31:2], 2'b00}; exp_be = m_be(f3, a); exp_wd = m_wd(f3, wd);
    set_idle();
    exp_stall = 1'b1;
    @(posedge clk); #1;
    fin = 1'b0; tmo = 1'b0;
    if (!mis) begin
      for (n = 0; n < TMO && !fin; n++) begin
        funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        exp_stall = 1'b1; exp_req = (n <= g); chk_bus = (n <= g); exp_err = 1'b0;
        exp_rdata = rd_hold;
        bus_gnt    = (n == g);
        bus_rvalid = (n == g + r) ? 1'b1 : ((n < g) ? 1'($urandom % 2) : 1'b0);
        bus_rdata  = (n == g + r) ? rw : $urandom;
        fin = rd ? (n == g + r) : (n == g);
        if (!fin && n == TMO - 1) tmo = 1'b1;
        @(posedge clk); #1;
      end
    end
    bus_gnt = 1'b0; bus_rvalid = 1'($urandom % 2); bus_rdata = $urandom;
    if (mis || tmo) rd_hold = 32'h0;
    else if (rd) rd_hold = m_load(f3, a, rw);
    set_idle();
    exp_err = mis || tmo;
    @(posedge clk); #1;
    mem_rd = 1'b0; mem_wr = 1'b0; bus_rvalid = 1'b0;
    set_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0, r0, e0;
    // reset state, with an access presented while rst is low
    enable = 1'b1; mem_rd = 1'b1;
    #2;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_req", 32'(bus_req), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_be", 32'(bus_be), 32'h0);
    @(posedge clk); #1;
    mem_rd = 1'b0; rst = 1'b1;
    set_idle(); chk_on = 1'b1;
    @(posedge clk); #1;

    // SW 0xDEADBEEF @0x100, immediate gnt
    s0 = stall_cnt; e0 = err_cnt;
    txn(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
    chk("sw_be", 32'(last_be), 32'hF);
    chk("sw_wd", last_wd, 32'hDEADBEEF);
    chk("sw_stall_cycles", 32'(stall_cnt - s0), 32'd2);
    chk("sw_err", 32'(err_cnt - e0), 32'd0);

    // SB 0xA5 @0x103
    txn(0, 1, 3'b000, 32'h103, 32'h000000A5, 1, 0, 32'h0);
    chk("sb_addr", last_addr, 32'h100);
    chk("sb_be", 32'(last_be), 32'b1000);
    chk("sb_wd", last_wd, 32'hA5A5A5A5);

    // byte/half loads
    s0 = stall_cnt;
    txn(1, 0, 3'b000, 32'h102, 32'h0, 0, 2, 32'h0080FF00);
    chk("lb_lit", rdata, 32'hFFFFFF80);
    chk("lb_stall_cycles", 32'(stall_cnt - s0), 32'd4);
    txn(1, 0, 3'b100, 32'h102, 32'h0, 0, 2, 32'h0080FF00);
    chk("lbu_lit", rdata, 32'h00000080);
    txn(1, 0, 3'b001, 32'h102, 32'h0, 1, 0, 32'h80011234);
    chk("lh_lit", rdata, 32'hFFFF8001);
    txn(1, 0, 3'b101, 32'h102, 32'h0, 0, 1, 32'h80011234);
    chk("lhu_lit", rdata, 32'h00008001);

    // LW with no grant: timeout
    s0 = stall_cnt; r0 = req_cnt; e0 = err_cnt;
    txn(1, 0, 3'b010, 32'h200, 32'h0, 1000, 0, 32'h0);
    chk("tmo_req_cycles", 32'(req_cnt - r0), 32'(TMO));
    chk("tmo_stall_cycles", 32'(stall_cnt - s0), 32'(TMO + 1));
    chk("tmo_err_pulses", 32'(err_cnt - e0), 32'd1);
    chk("tmo_rdata", rdata, 32'h0);

    // LH @0x101
    s0 = stall_cnt; r0 = req_cnt; e0 = err_cnt;
    txn(1, 0, 3'b001, 32'h101, 32'h0, 0, 0, 32'h12345678);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_req_cycles", 32'(req_cnt - r0), 32'd0);
    chk("mis_stall_cycles", 32'(stall_cnt - s0), 32'd1);
    chk("mis_err_pulses", 32'(err_cnt - e0), 32'd1);
    chk("mis_rdata", rdata, 32'h0);
`else
    chk("mis_be", 32'(last_be), 32'b0011);
    chk("mis_rdata", rdata, 32'h00005678);
    chk("mis_err_pulses", 32'(err_cnt - e0), 32'd0);
`endif

    // enable low: no acceptance in IDLE, and REQ plus its counter freeze
    enable = 1'b0; mem_wr = 1'b1; funct3 = 3'b010; addr = 32'h240; wdata = 32'h11223344;
    set_idle();
    repeat (2) begin @(posedge clk); #1; end
    enable = 1'b1; exp_stall = 1'b1;
    exp_we = 1'b1; exp_addr = 32'h240; exp_be = 4'hF; exp_wd = 32'h11223344;
    @(posedge clk); #1;
    enable = 1'b0; exp_req = 1'b1; chk_bus = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    enable = 1'b1;
    repeat (TMO - 2) begin @(posedge clk); #1; end
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0; mem_wr = 1'b0;
    set_idle();
    @(posedge clk); #1;

    // randomized accesses
    for (int i = 0; i < 150; i++) begin
      logic [2:0] f;
      bit rd, wr;
      int g, r;
      f  = 3'($urandom);
      rd = 1'($urandom % 2);
      wr = !rd || 1'($urandom % 2);
      g  = ($urandom % 8 == 0) ? 50 : int'($urandom % 4);
      r  = ($urandom % 8 == 0) ? 50 : int'($urandom % 4);
      txn(rd, wr, f, $urandom, $urandom, g, r, $urandom);
      if ($urandom % 3 == 0) begin @(posedge clk); #1; end
    end

    // reset asserted during WAIT
    txn(1, 0, 3'b010, 32'h40, 32'h0, 0, 0, 32'hCAFEF00D);
    chk("lw_lit", rdata, 32'hCAFEF00D);
    mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h300;
    set_idle(); exp_stall = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b1; exp_req = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0; chk_on = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_req", 32'(bus_req), 32'h0);
    chk("arst_stall", 32'(stall), 32'h0);
    chk("arst_rdata", rdata, 32'h0);
    chk("arst_err", 32'(err), 32'h0);
    chk("arst_bus", {bus_addr[31:4], bus_be ^ bus_addr[3:0]}, 32'h0);
    chk("arst_wd_we", bus_wdata | 32'(bus_we), 32'h0);
    @(posedge clk); #1;
    mem_rd = 1'b0; rst = 1'b1; rd_hold = 32'h0;
    set_idle(); chk_on = 1'b1;
    txn(1, 0, 3'b101, 32'h302, 32'h0, 1, 1, 32'h7FFE0000);
    chk("post_rst_lhu", rdata, 32'h00007FFE);
    @(posedge clk); #1;

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
